// File: rtl/timer_mmss_display_pkg.sv
// Shared types and constants for the MM:SS seven-segment display block.
// Holds the conversion FSM states and the active-low segment encoder.
package timer_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MIN,
    ST_SECT,
    ST_MINT,
    ST_COMMIT
  } conv_state_t;

  localparam int          SEC_PER_MIN = 60;
  localparam int          MAX_DISP    = 5999;
  localparam logic [6:0]  BLANK_SEG   = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0; non-decimal codes blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = BLANK_SEG;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/timer_mmss_display_if.sv
// Seconds input and display-pin bundle between the timer and the board.
// master drives the seconds count; slave is the display block.
interface timer_mmss_display_if #(
  parameter int IN_WIDTH = 10
);
  logic [IN_WIDTH-1:0] i_cnt;
  logic [6:0]          o_seg;
  logic [3:0]          o_an;
  logic                o_dp;
  logic                o_busy;

  modport master (output i_cnt, input o_seg, o_an, o_dp, o_busy);
  modport slave  (input i_cnt, output o_seg, o_an, o_dp, o_busy);
endinterface

// File: rtl/timer_mmss_display_convert.sv
// Binary seconds to MM:SS BCD by repeated subtraction, one step per cycle.
// Display digits change only on a COMMIT whose snapshot still matches the input.
module mmss_convert
  import timer_disp_pkg::*;
#(
  parameter int IN_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] i_cnt,
  output logic [3:0]          o_s_units,
  output logic [3:0]          o_s_tens,
  output logic [3:0]          o_m_units,
  output logic [3:0]          o_m_tens,
  output logic                o_busy
);

  conv_state_t         r_state;
  logic [IN_WIDTH-1:0] r_snap;
  logic [IN_WIDTH-1:0] r_rem;
  logic [6:0]          r_min;
  logic [3:0]          r_s_tens, r_s_units, r_m_tens, r_m_units;
  logic [3:0]          r_d_s_units, r_d_s_tens, r_d_m_units, r_d_m_tens;
  logic                r_busy;
  logic [IN_WIDTH-1:0] w_load;

  // Only widths able to exceed 99:59 need the clamp.
  generate
    if (IN_WIDTH > 12) begin : g_sat
      assign w_load = (i_cnt > IN_WIDTH'(MAX_DISP)) ? IN_WIDTH'(MAX_DISP) : i_cnt;
    end else begin : g_nosat
      assign w_load = i_cnt;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_snap      <= '0;
      r_rem       <= '0;
      r_min       <= '0;
      r_s_tens    <= '0;
      r_s_units   <= '0;
      r_m_tens    <= '0;
      r_m_units   <= '0;
      r_d_s_units <= '0;
      r_d_s_tens  <= '0;
      r_d_m_units <= '0;
      r_d_m_tens  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cnt != r_snap) begin
            r_snap   <= i_cnt;
            r_rem    <= w_load;
            r_min    <= '0;
            r_s_tens <= '0;
            r_m_tens <= '0;
            r_state  <= ST_MIN;
            r_busy   <= 1'b1;
          end
        end
        ST_MIN: begin
          if (r_rem >= IN_WIDTH'(SEC_PER_MIN)) begin
            r_rem <= r_rem - IN_WIDTH'(SEC_PER_MIN);
            r_min <= r_min + 7'd1;
          end else begin
            r_state <= ST_SECT;
          end
        end
        ST_SECT: begin
          if (r_rem >= IN_WIDTH'(10)) begin
            r_rem    <= r_rem - IN_WIDTH'(10);
            r_s_tens <= r_s_tens + 4'd1;
          end else begin
            r_s_units <= r_rem[3:0];
            r_state   <= ST_MINT;
          end
        end
        ST_MINT: begin
          if (r_min >= 7'd10) begin
            r_min    <= r_min - 7'd10;
            r_m_tens <= r_m_tens + 4'd1;
          end else begin
            r_m_units <= r_min[3:0];
            r_state   <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // A result already superseded by a newer input is dropped, not shown.
          if (i_cnt == r_snap) begin
            r_d_s_units <= r_s_units;
            r_d_s_tens  <= r_s_tens;
            r_d_m_units <= r_m_units;
            r_d_m_tens  <= r_m_tens;
          end
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_units = r_d_s_units;
  assign o_s_tens  = r_d_s_tens;
  assign o_m_units = r_d_m_units;
  assign o_m_tens  = r_d_m_tens;
  assign o_busy    = r_busy;

endmodule

// File: rtl/timer_mmss_display.sv
// MM:SS driver for a 4-digit common-anode display, one digit lit per SCAN_DIV cycles.
// Digit enable, segments and colon are registered together from the next scan index.
module timer_mmss_display
  import timer_disp_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  timer_mmss_display_if.slave   bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]    w_s_units, w_s_tens, w_m_units, w_m_tens;
  logic          w_busy;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          w_wrap;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_nxt;

  mmss_convert #(.IN_WIDTH(IN_WIDTH)) u_convert (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cnt     (bus.i_cnt),
    .o_s_units (w_s_units),
    .o_s_tens  (w_s_tens),
    .o_m_units (w_m_units),
    .o_m_tens  (w_m_tens),
    .o_busy    (w_busy)
  );

  assign w_wrap    = (r_scan_cnt == CW'(SCAN_DIV - 1));
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

  always_comb begin
    w_digit = w_s_units;
    case (w_idx_nxt)
      2'd0: w_digit = w_s_units;
      2'd1: w_digit = w_s_tens;
      2'd2: w_digit = w_m_units;
      2'd3: w_digit = w_m_tens;
      default: w_digit = w_s_units;
    endcase
    w_seg_nxt = seg7_encode(w_digit);
    // Leading zero of the minutes is suppressed while its digit stays enabled.
    if (w_idx_nxt == 2'd3 && w_digit == 4'd0) begin
      w_seg_nxt = BLANK_SEG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
      r_an       <= 4'b1110;
      r_seg      <= 7'b1000000;
      r_dp       <= 1'b1;
    end else begin
      r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + CW'(1);
      r_idx      <= w_idx_nxt;
      r_an       <= ~(4'b0001 << w_idx_nxt);
      r_seg      <= w_seg_nxt;
      r_dp       <= (w_idx_nxt != 2'd2);
    end
  end

  assign bus.o_an   = r_an;
  assign bus.o_seg  = r_seg;
  assign bus.o_dp   = r_dp;
  assign bus.o_busy = w_busy;

endmodule

// File: tb/tb_timer_mmss_display.sv
// Randomized self-checking bench for timer_mmss_display against an arithmetic MM:SS model.
module tb_timer_mmss_display;

  localparam int IW = 13;
  localparam int SD = 16;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cur;
  logic [6:0] disp_seg [4];
  int   dp_bad;
  int   an_bad;

  timer_mmss_display_if #(.IN_WIDTH(IW)) bus ();

  timer_mmss_display #(.IN_WIDTH(IW), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int ref_sat(input int v);
    return (v > 5999) ? 5999 : v;
  endfunction

  function automatic int ref_lat(input int v);
    int m, s;
    m = ref_sat(v) / 60;
    s = ref_sat(v) % 60;
    return m + s / 10 + m / 10 + 4;
  endfunction

  function automatic logic [6:0] ref_digit_seg(input int v, input int pos);
    int m, s, d;
    m = ref_sat(v) / 60;
    s = ref_sat(v) % 60;
    case (pos)
      0: d = s % 10;
      1: d = s / 10;
      2: d = m % 10;
      default: d = m / 10;
    endcase
    if (pos == 3 && d == 0) return 7'h7F;
    return SEG_TAB[d];
  endfunction

  task automatic measure_busy(output int len);
    int t;
    t = 0;
    len = 0;
    while (!bus.o_busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_busy) begin
      len = -1;
    end else begin
      while (bus.o_busy && len < 300) begin
        @(negedge clk);
        len++;
      end
    end
  endtask

  task automatic read_display();
    dp_bad = 0;
    an_bad = 0;
    for (int k = 0; k < 4; k++) disp_seg[k] = 7'h00;
    for (int i = 0; i < 4 * SD + 4; i++) begin
      @(negedge clk);
      case (bus.o_an)
        4'b1110: begin disp_seg[0] = bus.o_seg; if (!bus.o_dp) dp_bad++; end
        4'b1101: begin disp_seg[1] = bus.o_seg; if (!bus.o_dp) dp_bad++; end
        4'b1011: begin disp_seg[2] = bus.o_seg; if (bus.o_dp)  dp_bad++; end
        4'b0111: begin disp_seg[3] = bus.o_seg; if (!bus.o_dp) dp_bad++; end
        default: an_bad++;
      endcase
    end
  endtask

  task automatic check_display(input string tag, input int v);
    read_display();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_d%0d", tag, k), int'(disp_seg[k]), int'(ref_digit_seg(v, k)));
    end
    chk({tag, "_dp"}, dp_bad, 0);
    chk({tag, "_an"}, an_bad, 0);
  endtask

  task automatic apply_and_check(input string tag, input int v);
    int len;
    @(negedge clk);
    bus.i_cnt = IW'(v);
    cur = v;
    measure_busy(len);
    chk({tag, "_lat"}, len, ref_lat(v));
    check_display(tag, v);
  endtask

  initial begin
    int len;
    int dwell;
    int seen_old;
    logic [3:0] prev_an;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.i_cnt = IW'(600);
    cur = 600;
    repeat (3) @(negedge clk);
    chk("rst_an", int'(bus.o_an), 'b1110);
    chk("rst_seg", int'(bus.o_seg), 'b1000000);
    chk("rst_dp", int'(bus.o_dp), 1);
    chk("rst_busy", int'(bus.o_busy), 0);

    rst_n = 1'b1;
    measure_busy(len);
    chk("init_lat", len, 15);

    // Scan walk: each digit dwells SD cycles and the enable rotates toward bit3.
    prev_an = bus.o_an;
    dwell = 0;
    while (bus.o_an == prev_an && dwell < 4 * SD) begin @(negedge clk); dwell++; end
    for (int r = 0; r < 4; r++) begin
      prev_an = bus.o_an;
      dwell = 0;
      while (bus.o_an == prev_an && dwell < 4 * SD) begin @(negedge clk); dwell++; end
      chk($sformatf("scan_dwell%0d", r), dwell, SD);
      chk($sformatf("scan_next%0d", r), int'(bus.o_an), int'({prev_an[2:0], prev_an[3]}));
    end
    check_display("init", 600);

    apply_and_check("dec599", 599);
    apply_and_check("zero", 0);
    apply_and_check("pre", 1234);

    // Superseded value must never reach the display.
    @(negedge clk);
    bus.i_cnt = IW'(600);
    repeat (3) @(negedge clk);
    bus.i_cnt = IW'(59);
    cur = 59;
    seen_old = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_an == 4'b0111 && bus.o_seg == SEG_TAB[1]) seen_old++;
    end
    chk("midchg_no_1000", seen_old, 0);
    check_display("midchg", 59);

    apply_and_check("sat", 8000);

    @(negedge clk);
    bus.i_cnt = IW'(3000);
    cur = 3000;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", int'(bus.o_an), 'b1110);
    chk("arst_seg", int'(bus.o_seg), 'b1000000);
    chk("arst_dp", int'(bus.o_dp), 1);
    chk("arst_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(len);
    chk("arst_lat", len, ref_lat(3000));
    check_display("arst", 3000);

    for (int n = 0; n < 10; n++) begin
      int v;
      v = int'($urandom_range(0, 8191));
      if (v == cur) v = (v + 1) % 8192;
      apply_and_check($sformatf("rnd%0d", n), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_mmss_display.md
Name: timer_mmss_display

Overview:
- Downstream consumer of the countdown timer's seconds value.
- Converts the binary seconds count into minutes:seconds BCD (MM:SS) using a sequential repeated-subtraction FSM.
- Drives a 4-digit common-anode 7-segment display, scanning one digit at a time.
- Sits between the timer output and the board display pins.

Parameters:
- IN_WIDTH, 10: width of i_cnt. Supported range 7..13.
- SCAN_DIV, 1024: clk cycles each digit stays enabled. Minimum 2.

Ports:
- clk  input  1: clock.
- rst_n  input  1: reset, asynchronous, active-low.
- i_cnt  input  IN_WIDTH: seconds remaining, binary, from the timer.
- o_seg  output  7: segments {g,f,e,d,c,b,a}, active-low.
- o_an  output  4: digit enables, one-hot, active-low. Bit0 = seconds units, bit3 = minutes tens.
- o_dp  output  1: colon/decimal point, active-low.
- o_busy  output  1: conversion in progress.

Behaviour:
- Reset values:
  - snap = 0, all display BCD registers = 0, scan index = 0, scan counter = 0.
  - o_an = 4'b1110, o_seg = 7'b1000000 (digit "0"), o_dp = 1, o_busy = 0, FSM in IDLE.
- FSM states: IDLE, MIN, SECT, MINT, COMMIT.
- IDLE:
  - If i_cnt != snap: snap <= i_cnt, rem <= i_cnt (saturated to 5999 when i_cnt >= 6000), min <= 0, go to MIN.
  - Otherwise stay in IDLE.
  - Because snap resets to 0, a nonzero i_cnt starts a conversion in the first cycle after reset release.
- MIN: while rem >= 60, rem -= 60 and min += 1 (one step per cycle). Otherwise go to SECT.
- SECT: while rem >= 10, rem -= 10 and s_tens += 1. Otherwise s_units <= rem, go to MINT.
- MINT: while min >= 10, min -= 10 and m_tens += 1. Otherwise m_units <= min, go to COMMIT.
- COMMIT:
  - Copy all four working digits into the display registers in one edge, so the display never shows a mixed value.
  - Return to IDLE.
  - If i_cnt != snap at this point, IDLE restarts conversion on the next cycle. Intermediate values are dropped; the latest value always wins.
- o_busy = 1 in every state except IDLE (registered, derived from state).
- Latency: first display change appears L edges after the capture edge, where L = floor(v/60) + floor(s/10) + floor(m/10) + 4.
  - Example: v = 600 gives m = 10, s = 0, so L = 10 + 0 + 1 + 4 = 15.
- Width rules:
  - rem is IN_WIDTH bits.
  - Minutes are held in 7 bits (saturation guarantees at most 99).
  - All BCD digits are 4 bits.
- Scan:
  - A free-running counter counts 0..SCAN_DIV-1. On wrap, the scan index advances 0→1→2→3→0.
  - The counter is independent of the conversion FSM.
  - o_an and o_seg are registered and updated together, so there are no ghosting glitches.
- Segment output:
  - o_seg shows the decoded digit for the current index.
  - Minutes-tens digit of 0 is blanked: o_seg = 7'h7F while its o_an bit is still low.
- o_dp = 0 only while index == 2 (minutes units digit, which forms the colon).
- Reset mid-conversion: immediate return to the reset values. The partial result is discarded.

Decomposition:
- Package timer_disp_pkg holds:
  - FSM state enum.
  - Constants SEC_PER_MIN = 60, MAX_DISP = 5999, BLANK_SEG = 7'h7F.
  - Function seg7_encode(bcd) → active-low pattern; values 10..15 map to blank.
- Sub-module mmss_convert: the conversion FSM plus snap. Outputs the 4 committed BCD digits and busy.
- The top level holds the scan counter and output registers.

Test Plan:
- Reset release with i_cnt = 600 → o_busy high for 15 cycles; committed digits 1,0,0,0; o_an walks 1110→1101→1011→0111 every 1024 cycles; o_dp = 0 only at 1011.
- Single change: i_cnt 600→599 → after 9+5+0+4 = 18 cycles the display reads 09:59 with the minutes tens blanked (o_seg = 7'h7F while o_an = 0111).
- i_cnt = 0 → display reads " 0:00" with the leading digit blanked; o_busy high for exactly 4 cycles.
- Change mid-conversion: 600 then 59 applied 3 cycles later → the display never shows 10:00; it ends at " 0:59" after the restart.
- Saturation with IN_WIDTH = 13, i_cnt = 8000 → display reads 99:59.
- rst_n asserted mid-conversion (during MIN) → all outputs take their reset values immediately; after release the conversion runs fresh from the current i_cnt.
